cronometro_mmss_bcd: RTL and testbench
======================================

// Module: cronometro_mmss_bcd
// PURPOSE
//  mm:ss stopwatch that feeds the 4-digit 7-segment multiplexer stage.
//  Debounces the start/stop and clear buttons and divides clock_50mhz down to a 1 Hz tick.
//  Outputs four BCD digits plus a colon-blink bit; the display mux decodes and scans them.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency; tick period = CLK_HZ/TICK_HZ cycles
//  TICK_HZ     1           count rate of the seconds digit
//  DEB_CYCLES  1_000_000   cycles a button level must stay stable to be accepted (20 ms)
// PORTS
//  clock_50mhz     in   1   system clock, all logic on posedge
//  reset_n         in   1   synchronous, active-low reset
//  btn_start_stop  in   1   raw pushbutton, active-high, asynchronous to clock
//  btn_clear       in   1   raw pushbutton, active-high, asynchronous to clock
//  digitos         out  16  {min_tens, min_units, sec_tens, sec_units}, 4-bit BCD each
//  corriendo       out  1   1 while state == CORRIENDO
//  punto           out  1   colon / decimal-point drive, active-high
//  tick_1hz        out  1   one-cycle pulse on each counted second
//  desborde        out  1   1 while state == LIMITE (59:59 reached)
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge): digitos=0, corriendo=0, tick_1hz=0, desborde=0,
//   punto=1, state=DETENIDO, prescaler=0, debouncers stable=0, sync FFs=0.
//  Buttons: 2-FF synchronizer, then debounce. The stable level updates only after the synced
//   level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
//   A 0->1 change of the stable level gives a one-cycle press pulse. Raw edge -> pulse
//   latency = 2 + DEB_CYCLES cycles. The state reacts on the following edge.
//  FSM states: DETENIDO, CORRIENDO, LIMITE.
//   DETENIDO --start_stop--> CORRIENDO; CORRIENDO --start_stop--> DETENIDO (pause).
//   CORRIENDO --tick while digitos==16'h5959--> LIMITE; LIMITE ignores start_stop.
//   Any state --clear--> DETENIDO with digitos=0 and prescaler=0.
//  Prescaler counts 0..CLK_HZ/TICK_HZ-1 only in CORRIENDO. In DETENIDO it holds its value,
//   so a pause resumes mid-second. On wrap it gives tick_1hz=1 for one cycle.
//  Count on tick: sec_units 0..9, carry to sec_tens 0..5, carry to min_units 0..9,
//   carry to min_tens 0..5. At 59:59 the digits hold, desborde=1, no wrap to 00:00.
//   Digit values above 9 (or above 5 for the tens digits) never occur.
//  punto: CORRIENDO -> 1 while prescaler < half period, else 0; DETENIDO -> 1; LIMITE -> 0.
//  All outputs are registered; the new digit value appears on the edge after the tick pulse.
//  Simultaneous events: clear beats start_stop and beats tick in the same cycle.
//   A start_stop pulse and a tick in the same cycle: the tick is counted first, then the
//   state toggles.
//  reset_n low mid-count or mid-debounce discards all progress; no partial pulse is emitted.
// STRUCTURE
//  Shared package cronometro_pkg:
//   state encoding (DETENIDO=2'd0, CORRIENDO=2'd1, LIMITE=2'd2),
//   BCD limits (BCD_MAX_UNITS=4'd9, BCD_MAX_TENS=4'd5), LIMITE_VALUE=16'h5959.
//  Sub-module antirrebote: synchronizer + debounce + rising-edge pulse, parameter DEB_CYCLES.
//   Instantiated twice, once per button.
//  Top level holds the prescaler, the FSM, the BCD cascade and the punto logic.
// TESTING (bench parameters: CLK_HZ=20, TICK_HZ=1, DEB_CYCLES=4)
//  1. Reset: hold reset_n=0 for 3 cycles -> digitos=16'h0000, punto=1, corriendo=0, desborde=0.
//  2. Bounce: press start_stop with 0/1 glitches shorter than 4 cycles, then hold high
//     -> exactly one press pulse; corriendo=1; first tick_1hz 20 cycles later, digitos=16'h0001.
//  3. Pause: stop at prescaler=7, wait 100 cycles, start again -> next tick 13 cycles after
//     resume; digitos does not change while stopped.
//  4. Carry: run from 00:09 -> 00:10, and from 09:59 -> 10:00, on a single tick each.
//  5. Limit: preload by running to 59:59, one more tick -> digitos=16'h5959, desborde=1,
//     punto=0; a start_stop press is ignored; clear -> 16'h0000, DETENIDO, desborde=0.
//  6. Collision: clear and tick in the same cycle -> digitos=16'h0000, no increment,
//     corriendo=0.

Source files
------------

// File: rtl/cronometro_pkg.sv
// Shared definitions for the mm:ss stopwatch: state encoding, BCD limits, count helper.
package cronometro_pkg;

    typedef enum logic [1:0] {
        DETENIDO  = 2'd0,
        CORRIENDO = 2'd1,
        LIMITE    = 2'd2
    } estado_t;

    localparam logic [3:0]  BCD_MAX_UNITS = 4'd9;
    localparam logic [3:0]  BCD_MAX_TENS  = 4'd5;
    localparam logic [15:0] LIMITE_VALUE  = 16'h5959;

    // Advance {min_tens, min_units, sec_tens, sec_units} by one second (caller keeps it below the limit)
    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[3:0] != BCD_MAX_UNITS) begin
            r[3:0] = d[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (d[7:4] != BCD_MAX_TENS) begin
                r[7:4] = d[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (d[11:8] != BCD_MAX_UNITS) begin
                    r[11:8] = d[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (d[15:12] != BCD_MAX_TENS) begin
                        r[15:12] = d[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// Pushbutton conditioner: 2-FF synchronizer, stability debounce, one-cycle press pulse.
module antirrebote #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulso
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_estable;
    logic             r_pulso;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fin;

    assign w_fin   = (r_cnt == CNT_W'(DEB_CYCLES - 1));
    assign o_pulso = r_pulso;

    // Bring the raw button into the clock domain
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it differs for DEB_CYCLES straight cycles; pulse on acceptance of 1
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_estable <= 1'b0;
            r_cnt     <= '0;
            r_pulso   <= 1'b0;
        end else begin
            r_pulso <= 1'b0;
            if (r_sync2 != r_estable) begin
                if (w_fin) begin
                    r_estable <= r_sync2;
                    r_cnt     <= '0;
                    r_pulso   <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cronometro_mmss_bcd.sv
// mm:ss BCD stopwatch: button conditioning, 1 Hz prescaler, run/stop/limit FSM, colon blink.
module cronometro_mmss_bcd #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic        clock_50mhz,
    input  logic        reset_n,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    output logic [15:0] digitos,
    output logic        corriendo,
    output logic        punto,
    output logic        tick_1hz,
    output logic        desborde
);

    import cronometro_pkg::*;

    localparam int unsigned PERIODO = CLK_HZ / TICK_HZ;
    localparam int unsigned PRESC_W = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int unsigned MITAD   = PERIODO / 2;

    estado_t            r_estado;
    logic [15:0]        r_digitos;
    logic               r_corriendo;
    logic               r_desborde;
    logic               r_punto;
    logic               r_tick;
    logic [PRESC_W-1:0] r_presc;

    logic               w_start_stop;
    logic               w_clear;
    logic               w_wrap;
    logic               w_punto_run;
    logic [PRESC_W-1:0] w_presc_nxt;

    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .i_clk   (clock_50mhz),
        .i_rst_n (reset_n),
        .i_btn   (btn_start_stop),
        .o_pulso (w_start_stop)
    );

    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .i_clk   (clock_50mhz),
        .i_rst_n (reset_n),
        .i_btn   (btn_clear),
        .o_pulso (w_clear)
    );

    assign w_wrap      = !w_clear && (r_estado == CORRIENDO) && (r_presc == PRESC_W'(PERIODO - 1));
    assign w_punto_run = (w_presc_nxt < PRESC_W'(MITAD));

    // Prescaler next value: advances only while running, holds while paused, cleared by clear
    always_comb begin
        w_presc_nxt = r_presc;
        if (w_clear) begin
            w_presc_nxt = '0;
        end else if (r_estado == CORRIENDO) begin
            w_presc_nxt = w_wrap ? '0 : r_presc + PRESC_W'(1);
        end
    end

    // Prescaler register and one-cycle tick on wrap
    always_ff @(posedge clock_50mhz) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_tick  <= w_wrap;
        end
    end

    // Run/stop/limit FSM with BCD count; a tick is counted before a start_stop toggle
    always_ff @(posedge clock_50mhz) begin
        if (!reset_n || w_clear) begin
            r_estado    <= DETENIDO;
            r_digitos   <= '0;
            r_corriendo <= 1'b0;
            r_desborde  <= 1'b0;
            r_punto     <= 1'b1;
        end else begin
            if (r_tick && (r_digitos != LIMITE_VALUE)) begin
                r_digitos <= bcd_inc(r_digitos);
            end
            case (r_estado)
                DETENIDO: begin
                    if (w_start_stop) begin
                        r_estado    <= CORRIENDO;
                        r_corriendo <= 1'b1;
                        r_punto     <= w_punto_run;
                    end
                end
                CORRIENDO: begin
                    if (r_tick && (r_digitos == LIMITE_VALUE)) begin
                        r_estado    <= LIMITE;
                        r_corriendo <= 1'b0;
                        r_desborde  <= 1'b1;
                        r_punto     <= 1'b0;
                    end else if (w_start_stop) begin
                        r_estado    <= DETENIDO;
                        r_corriendo <= 1'b0;
                        r_punto     <= 1'b1;
                    end else begin
                        r_punto <= w_punto_run;
                    end
                end
                LIMITE: begin
                    r_punto <= 1'b0;
                end
                default: begin
                    r_estado    <= DETENIDO;
                    r_corriendo <= 1'b0;
                    r_desborde  <= 1'b0;
                    r_punto     <= 1'b1;
                end
            endcase
        end
    end

    assign digitos   = r_digitos;
    assign corriendo = r_corriendo;
    assign punto     = r_punto;
    assign tick_1hz  = r_tick;
    assign desborde  = r_desborde;

endmodule

// File: tb/tb_cronometro_mmss_bcd.sv
// Bench for cronometro_mmss_bcd: seconds-count reference model feeding a scoreboard queue.
module tb_cronometro_mmss_bcd;

    localparam int PER  = 20;
    localparam int HALF = PER / 2;
    localparam int DEB  = 4;
    localparam int MAXS = 3599;
    localparam int M_STOP = 0;
    localparam int M_RUN  = 1;
    localparam int M_LIM  = 2;

    typedef struct packed {
        logic [15:0] dig;
        logic        run;
        logic        pto;
        logic        tck;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        btn_start_stop;
    logic        btn_clear;
    logic [15:0] digitos;
    logic        corriendo;
    logic        punto;
    logic        tick_1hz;
    logic        desborde;

    int total;
    int bad;
    int ncyc;
    exp_t sb[$];

    // Reference model state
    int m_s1[2];
    int m_s2[2];
    int m_stable[2];
    int m_run[2];
    int m_pulse[2];
    int m_state;
    int m_secs;
    int m_presc;
    int m_tick;
    int m_punto;

    cronometro_mmss_bcd #(.CLK_HZ(PER), .TICK_HZ(1), .DEB_CYCLES(DEB)) dut (
        .clock_50mhz    (clk),
        .reset_n        (reset_n),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .digitos        (digitos),
        .corriendo      (corriendo),
        .punto          (punto),
        .tick_1hz       (tick_1hz),
        .desborde       (desborde)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] secs_to_bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Reference model: advance one clock and queue the outputs expected after this edge
    always @(posedge clk) begin : model
        int   ss_p;
        int   clr_p;
        int   tick_old;
        int   at_lim;
        int   was_run;
        int   raw[2];
        exp_t e;
        raw[0] = int'(btn_start_stop);
        raw[1] = int'(btn_clear);
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_stable[b] = 0; m_run[b] = 0; m_pulse[b] = 0;
            end
            m_state = M_STOP; m_secs = 0; m_presc = 0; m_tick = 0; m_punto = 1;
        end else begin
            ss_p  = m_pulse[0];
            clr_p = m_pulse[1];
            for (int b = 0; b < 2; b++) begin
                m_pulse[b] = 0;
                if (m_s2[b] != m_stable[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DEB) begin
                        m_stable[b] = m_s2[b];
                        m_run[b]    = 0;
                        m_pulse[b]  = m_stable[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
            tick_old = m_tick;
            if (clr_p != 0) begin
                m_state = M_STOP; m_secs = 0; m_presc = 0; m_tick = 0;
            end else begin
                was_run = (m_state == M_RUN) ? 1 : 0;
                m_tick  = (was_run != 0 && m_presc == PER - 1) ? 1 : 0;
                if (was_run != 0) m_presc = (m_presc + 1) % PER;
                at_lim = (m_secs == MAXS) ? 1 : 0;
                if (tick_old != 0 && at_lim == 0) m_secs = m_secs + 1;
                if (m_state == M_STOP) begin
                    if (ss_p != 0) m_state = M_RUN;
                end else if (m_state == M_RUN) begin
                    if (tick_old != 0 && at_lim != 0) m_state = M_LIM;
                    else if (ss_p != 0) m_state = M_STOP;
                end
            end
            if (m_state == M_RUN) m_punto = (m_presc < HALF) ? 1 : 0;
            else m_punto = (m_state == M_STOP) ? 1 : 0;
        end
        e.dig = secs_to_bcd(m_secs);
        e.run = (m_state == M_RUN);
        e.pto = (m_punto != 0);
        e.tck = (m_tick != 0);
        e.ovf = (m_state == M_LIM);
        sb.push_back(e);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return corriendo;
            1:       return tick_1hz;
            default: return desborde;
        endcase
    endfunction

    // Wait (bounded) until the chosen output equals val; n returns the number of cycles waited
    task automatic wait_flag(input string name, input int sel, input logic val, input int budget,
                             output int n);
        n = 0;
        while (sel_sig(sel) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sel_sig(sel) !== val) begin
            total++;
            bad++;
            $display("FAIL timeout %s: no change after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_dig(input string name, input logic [15:0] v, input int budget);
        int n;
        n = 0;
        while (digitos !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (digitos !== v) begin
            total++;
            bad++;
            $display("FAIL timeout %s: digitos=%h never reached %h", name, digitos, v);
        end
    endtask

    // Scoreboard monitor: pop the model's expectation and compare against the DUT outputs
    task automatic monitor();
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            ncyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = '{dig: digitos, run: corriendo, pto: punto, tck: tick_1hz, ovf: desborde};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL scoreboard cyc=%0d: got dig=%h run=%b pto=%b tck=%b ovf=%b, expected dig=%h run=%b pto=%b tck=%b ovf=%b",
                             ncyc, a.dig, a.run, a.pto, a.tck, a.ovf, e.dig, e.run, e.pto, e.tck, e.ovf);
                end
            end
        end
    endtask

    initial begin
        int          n;
        int          k;
        logic [15:0] held;
        total = 0;
        bad   = 0;
        ncyc  = 0;
        reset_n        = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        fork
            monitor();
        join_none

        // Reset
        cyc(3);
        check("reset_digitos", digitos, 16'h0000);
        check("reset_punto", 16'(punto), 16'h1);
        check("reset_corriendo", 16'(corriendo), 16'h0);
        check("reset_desborde", 16'(desborde), 16'h0);
        reset_n = 1'b1;
        cyc(2);

        // Bouncy start press: glitches shorter than the debounce window, then a solid hold
        k = int'($urandom_range(2, 4));
        for (int i = 0; i < k; i++) begin
            btn_start_stop = 1'b1;
            cyc(int'($urandom_range(1, 3)));
            btn_start_stop = 1'b0;
            cyc(int'($urandom_range(1, 3)));
        end
        btn_start_stop = 1'b1;
        wait_flag("start_run", 0, 1'b1, 20, n);
        check("start_corriendo", 16'(corriendo), 16'h1);
        wait_flag("first_tick", 1, 1'b1, 40, n);
        check("first_tick_delay", 16'(n), 16'd20);
        btn_start_stop = 1'b0;
        cyc(1);
        check("first_second", digitos, 16'h0001);

        // Pause mid-second and resume
        wait_flag("tick_before_pause", 1, 1'b1, 40, n);
        btn_start_stop = 1'b1;
        wait_flag("pause", 0, 1'b0, 20, n);
        held = digitos;
        check("pause_value", held, 16'h0002);
        cyc(2);
        btn_start_stop = 1'b0;
        cyc(98);
        check("pause_hold", digitos, held);
        btn_start_stop = 1'b1;
        wait_flag("resume", 0, 1'b1, 20, n);
        wait_flag("tick_after_resume", 1, 1'b1, 40, n);
        check("resume_tick_delay", 16'(n), 16'd13);
        cyc(2);
        btn_start_stop = 1'b0;

        // Carries
        wait_dig("reach_0009", 16'h0009, 400);
        wait_flag("tick_0009", 1, 1'b1, 40, n);
        cyc(1);
        check("carry_0010", digitos, 16'h0010);
        wait_dig("reach_0959", 16'h0959, 13000);
        wait_flag("tick_0959", 1, 1'b1, 40, n);
        cyc(1);
        check("carry_1000", digitos, 16'h1000);

        // Limit
        wait_flag("limit", 2, 1'b1, 75000, n);
        check("limit_digitos", digitos, 16'h5959);
        check("limit_punto", 16'(punto), 16'h0);
        check("limit_corriendo", 16'(corriendo), 16'h0);
        btn_start_stop = 1'b1;
        cyc(10);
        btn_start_stop = 1'b0;
        cyc(10);
        check("limit_ignores_start", 16'(desborde), 16'h1);
        check("limit_hold", digitos, 16'h5959);
        btn_clear = 1'b1;
        wait_flag("clear_limit", 2, 1'b0, 20, n);
        check("clear_digitos", digitos, 16'h0000);
        check("clear_corriendo", 16'(corriendo), 16'h0);
        check("clear_punto", 16'(punto), 16'h1);
        cyc(3);
        btn_clear = 1'b0;
        cyc(10);

        // Clear pulse landing on the same cycle as a tick
        btn_start_stop = 1'b1;
        wait_flag("restart", 0, 1'b1, 20, n);
        cyc(3);
        btn_start_stop = 1'b0;
        wait_flag("coll_tick1", 1, 1'b1, 40, n);
        cyc(1);
        wait_flag("coll_tick2", 1, 1'b1, 40, n);
        n = 0;
        while (!(m_state == M_RUN && m_presc == 14) && n < 40) begin
            @(negedge clk);
            n++;
        end
        btn_clear = 1'b1;
        wait_flag("coll_clear", 0, 1'b0, 20, n);
        check("coll_digitos", digitos, 16'h0000);
        check("coll_corriendo", 16'(corriendo), 16'h0);
        cyc(3);
        btn_clear = 1'b0;
        cyc(10);

        // Random button activity with occasional resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) btn_start_stop = ~btn_start_stop;
            if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
            reset_n = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        reset_n        = 1'b1;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
